// File: rtl/csr_pkg.sv
// Shared CSR constants: addresses, mstatus bit positions, misa value
// and mcause codes for the trap generator.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [31:0] CAUSE_INSN_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL_INSN    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT      = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M         = 32'd11;

endpackage

// File: rtl/csr_regfile_counter64.sv
// 64-bit counter; a write to either half suppresses the increment
// for the whole counter in that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) cnt_d[31:0]  = wdata_i;
      if (we_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file with trap/mret updates.
// Define CSR_COUNTERS_EN to add the mcycle/minstret counters.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned HART_ID     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic        csr_illegal,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instret,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic impl;
  logic ro;
  logic wr_ok;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .we_lo_i (wr_ok && csr_addr == CSR_MCYCLE),
    .we_hi_i (wr_ok && csr_addr == CSR_MCYCLEH),
    .wdata_i (csr_wdata),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (instret),
    .we_lo_i (wr_ok && csr_addr == CSR_MINSTRET),
    .we_hi_i (wr_ok && csr_addr == CSR_MINSTRETH),
    .wdata_i (csr_wdata),
    .cnt_o   (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = instret;
`endif

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    ro        = 1'b0;
    unique case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[12:11]        = 2'b11;
        csr_rdata[MSTATUS_MIE]  = mie_q;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MISA: begin
        csr_rdata = MISA_VALUE;
        ro        = 1'b1;
      end
      CSR_MHARTID: begin
        csr_rdata = 32'(HART_ID);
        ro        = 1'b1;
      end
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_CYCLE: begin
        csr_rdata = mcycle[31:0];
        ro        = 1'b1;
      end
      CSR_CYCLEH: begin
        csr_rdata = mcycle[63:32];
        ro        = 1'b1;
      end
      CSR_INSTRET: begin
        csr_rdata = minstret[31:0];
        ro        = 1'b1;
      end
      CSR_INSTRETH: begin
        csr_rdata = minstret[63:32];
        ro        = 1'b1;
      end
`endif
      default: impl = 1'b0;
    endcase
  end

  assign csr_illegal = !impl || (csr_we && ro);
  // trap and mret take the whole cycle; a coincident write is dropped
  assign wr_ok = csr_we && !csr_illegal && !trap && !mret;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap) begin
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_ok) begin
      unique case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata[MSTATUS_MIE];
          mpie_d = csr_wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = csr_wdata;
        CSR_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Vector table plus hand sequences for csr_regfile, checked through
// an expected-value queue.
module tb_csr_regfile;

  localparam logic [31:0] MTV = 32'h0000_0207;
  localparam int unsigned HID = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_illegal;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic        instret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  csr_regfile #(
    .MTVEC_RESET (MTV),
    .HART_ID     (HID)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_addr    (csr_addr),
    .csr_rdata   (csr_rdata),
    .csr_we      (csr_we),
    .csr_wdata   (csr_wdata),
    .csr_illegal (csr_illegal),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .trap_val    (trap_val),
    .mret        (mret),
    .instret     (instret),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .mie_o       (mie_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic [31:0] tval;
    logic        mret;
    logic [11:0] raddr;
    logic [31:0] exp;
    logic        ill;
    logic        mie;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input string n, input logic [31:0] e);
    sb_t it;
    it.name = n;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic pop_check(input logic [31:0] act);
    sb_t it;
    total++;
    if (sb_q.size() == 0) begin
      $display("FAIL sb_empty: got %h want <none>", act);
      return;
    end
    it = sb_q.pop_front();
    if (act === it.exp) passed++;
    else $display("FAIL %s: got %h want %h", it.name, act, it.exp);
  endtask

  task automatic chk(input string n, input logic [31:0] e,
                     input logic [31:0] act);
    push(n, e);
    pop_check(act);
  endtask

  task automatic idle();
    csr_we     = 1'b0;
    csr_wdata  = '0;
    trap       = 1'b0;
    trap_pc    = '0;
    trap_cause = '0;
    trap_val   = '0;
    mret       = 1'b0;
    instret    = 1'b0;
  endtask

  task automatic add(input logic [11:0] a, input logic we,
                     input logic [31:0] wd, input logic tr,
                     input logic [31:0] tpc, input logic [31:0] tc,
                     input logic [31:0] tv, input logic mr,
                     input logic [11:0] ra, input logic [31:0] e,
                     input logic ill, input logic mie);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = wd;
    v.trap = tr; v.tpc = tpc; v.tcause = tc; v.tval = tv;
    v.mret = mr; v.raddr = ra; v.exp = e; v.ill = ill; v.mie = mie;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    csr_addr   = v.addr;
    csr_we     = v.we;
    csr_wdata  = v.wdata;
    trap       = v.trap;
    trap_pc    = v.tpc;
    trap_cause = v.tcause;
    trap_val   = v.tval;
    mret       = v.mret;
    @(posedge clk);
    #1;
    idle();
    csr_addr = v.raddr;
    push($sformatf("v%0d_rdata", i), v.exp);
    push($sformatf("v%0d_ill", i), {31'b0, v.ill});
    push($sformatf("v%0d_mie", i), {31'b0, v.mie});
    #1;
    pop_check(csr_rdata);
    pop_check({31'b0, csr_illegal});
    pop_check({31'b0, mie_o});
  endtask

  initial begin
    rst      = 1'b1;
    csr_addr = '0;
    idle();

    //   addr    we wdata        tr tpc      tcause tval     mr raddr  exp           ill mie
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h300, 32'h0000_1800, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h305, 32'h0000_0204, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h301, 32'h4000_0100, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'hF14, 32'd5,         0, 0);
    add(12'h305, 1, 32'h8000_0103,0, 0,       0,  0,          0, 12'h305, 32'h8000_0100, 0, 0);
    add(12'h300, 1, 32'h8,        0, 0,       0,  0,          0, 12'h300, 32'h0000_1808, 0, 1);
    add(12'h000, 0, 0,            1, 32'h1236,11, 0,          0, 12'h341, 32'h0000_1234, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h342, 32'd11,        0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h300, 32'h0000_1880, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          1, 12'h300, 32'h0000_1888, 0, 1);
    add(12'h340, 1, 32'h1234_5678,0, 0,       0,  0,          0, 12'h340, 32'h1234_5678, 0, 1);
    add(12'h340, 1, 32'hDEAD,     1, 32'h2000,2,  32'hBAD,    0, 12'h340, 32'h1234_5678, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h343, 32'h0000_0BAD, 0, 0);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h300, 32'h0000_1880, 0, 0);
    add(12'h340, 1, 32'hBEEF,     0, 0,       0,  0,          1, 12'h340, 32'h1234_5678, 0, 1);
    add(12'h000, 0, 0,            0, 0,       0,  0,          0, 12'h300, 32'h0000_1888, 0, 1);
    add(12'h000, 0, 0,            1, 32'h3000,3,  0,          1, 12'h300, 32'h0000_1880, 0, 0);
    add(12'h301, 1, 32'h0,        0, 0,       0,  0,          0, 12'h301, 32'h4000_0100, 0, 0);
    add(12'h7C0, 1, 32'h5,        0, 0,       0,  0,          0, 12'h7C0, 32'h0,         1, 0);
    add(12'h341, 1, 32'h5557,     0, 0,       0,  0,          0, 12'h341, 32'h0000_5554, 0, 0);
    add(12'h343, 1, 32'hCAFE,     0, 0,       0,  0,          0, 12'h343, 32'h0000_CAFE, 0, 0);
    add(12'h342, 1, 32'h8000_0007,0, 0,       0,  0,          0, 12'h342, 32'h8000_0007, 0, 0);

    #12;
    rst = 1'b0;
    chk("rst_mtvec_o", 32'h0000_0204, mtvec_o);
    chk("rst_mepc_o", 32'h0, mepc_o);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    chk("mtvec_o", 32'h8000_0100, mtvec_o);
    chk("mepc_o", 32'h0000_5554, mepc_o);

    // illegal flag is combinational with csr_we
    @(negedge clk);
    csr_addr = 12'h301;
    csr_we   = 1'b1;
    #1 chk("ill_we_misa", 32'd1, {31'b0, csr_illegal});
    csr_addr = 12'hF14;
    #1 chk("ill_we_hartid", 32'd1, {31'b0, csr_illegal});
    csr_addr = 12'h340;
    #1 chk("ill_we_mscratch", 32'd0, {31'b0, csr_illegal});
    idle();
    csr_addr = 12'h300;

    // reset asserted mid-trap, between edges
    @(negedge clk);
    trap       = 1'b1;
    trap_pc    = 32'h4440;
    trap_cause = 32'd2;
    #2 rst = 1'b1;
    #1;
    chk("arst_mstatus", 32'h0000_1800, csr_rdata);
    chk("arst_mie", 32'd0, {31'b0, mie_o});
    chk("arst_mepc", 32'h0, mepc_o);
    chk("arst_mtvec", 32'h0000_0204, mtvec_o);
    @(negedge clk);
    idle();
    #2 rst = 1'b0;
    csr_addr = 12'h340;
    #1 chk("arst_mscratch", 32'h0, csr_rdata);
    csr_addr = 12'h342;
    #1 chk("arst_mcause", 32'h0, csr_rdata);

`ifdef CSR_COUNTERS_EN
    @(negedge clk);
    csr_addr  = 12'hB00;
    csr_we    = 1'b1;
    csr_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    csr_addr = 12'hB80;
    @(negedge clk);
    idle();
    csr_addr = 12'hB00;
    #1 chk("cyc_all1_lo", 32'hFFFF_FFFF, csr_rdata);
    csr_addr = 12'hB80;
    #1 chk("cyc_all1_hi", 32'hFFFF_FFFF, csr_rdata);
    @(posedge clk);
    #1 csr_addr = 12'hB00;
    #1 chk("cyc_wrap_lo", 32'h0, csr_rdata);
    csr_addr = 12'hB80;
    #1 chk("cyc_wrap_hi", 32'h0, csr_rdata);
    @(posedge clk);
    #1 csr_addr = 12'hC00;
    #1 chk("cyc_one_lo", 32'h1, csr_rdata);
    csr_addr = 12'hC80;
    #1 chk("cyc_one_hi", 32'h0, csr_rdata);

    @(negedge clk);
    csr_addr  = 12'hB02;
    csr_we    = 1'b1;
    csr_wdata = 32'd10;
    instret   = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
    @(negedge clk);
    instret  = 1'b0;
    csr_addr = 12'hC02;
    #1 chk("instret_cnt", 32'd11, csr_rdata);
    csr_addr = 12'hB82;
    #1 chk("instreth", 32'd0, csr_rdata);
    csr_addr = 12'hC00;
    csr_we   = 1'b1;
    #1 chk("ill_we_cycle", 32'd1, {31'b0, csr_illegal});
    idle();
`else
    csr_addr = 12'hB00;
    #1 chk("nocnt_rdata", 32'h0, csr_rdata);
    chk("nocnt_ill", 32'd1, {31'b0, csr_illegal});
    csr_addr = 12'hC02;
    #1 chk("nocnt_ill_c02", 32'd1, {31'b0, csr_illegal});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
